// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the RV32I multicycle controller:
// FSM states, opcodes and datapath mux/ALU select codes.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_LUI      = 4'd8,
      S_ALUWB    = 4'd9,
      S_JAL      = 4'd10,
      S_BRANCH   = 4'd11,
      S_ILLEGAL  = 4'd12
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [2:0] ALUC_ADD = 3'b000;
   localparam logic [2:0] ALUC_SUB = 3'b001;
   localparam logic [2:0] ALUC_AND = 3'b010;
   localparam logic [2:0] ALUC_OR  = 3'b011;
   localparam logic [2:0] ALUC_SLT = 3'b101;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // fetch/branch flag the states whose strobes also depend on live inputs
   typedef struct packed {
      logic       fetch;
      logic       branch;
      logic       pcwrite;
      logic       adrsrc;
      logic       memwrite;
      logic       regwrite;
      logic       illegal;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] alu_op;
   } moore_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller boundary: instruction fields and ALU flags in, datapath
// controls out. master = IR/datapath side, slave = controller.
interface multicycle_controller_if #(parameter int IMMSRC_W = 3);
   logic [6:0]          op;
   logic [2:0]          funct3;
   logic                funct7_5;
   logic                zero;
   logic                lt;
   logic                ltu;
   logic                mem_ready;
   logic                pcwrite;
   logic                adrsrc;
   logic                memwrite;
   logic                irwrite;
   logic                regwrite;
   logic [1:0]          resultsrc;
   logic [1:0]          alusrca;
   logic [1:0]          alusrcb;
   logic [IMMSRC_W-1:0] immsrc;
   logic [2:0]          alu_controls;
   logic                illegal;

   modport master (
      output op, funct3, funct7_5, zero, lt, ltu, mem_ready,
      input  pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
             alusrca, alusrcb, immsrc, alu_controls, illegal
   );

   modport slave (
      input  op, funct3, funct7_5, zero, lt, ltu, mem_ready,
      output pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
             alusrca, alusrcb, immsrc, alu_controls, illegal
   );
endinterface

// File: rtl/multicycle_controller_aludec.sv
// Combinational ALU operation decode from the FSM's alu_op and the
// instruction's funct fields.
module mc_aludec
   import riscv_ctrl_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       op5,
   output logic [2:0] alu_controls
);

   // funct7_5 only selects sub for register-register ops (op5 set)
   always_comb begin
      alu_controls = ALUC_ADD;
      case (alu_op)
         ALUOP_ADD: alu_controls = ALUC_ADD;
         ALUOP_SUB: alu_controls = ALUC_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               3'b000: begin
                  if (funct7_5 && op5) begin
                     alu_controls = ALUC_SUB;
                  end else begin
                     alu_controls = ALUC_ADD;
                  end
               end
               3'b010:  alu_controls = ALUC_SLT;
               3'b110:  alu_controls = ALUC_OR;
               3'b111:  alu_controls = ALUC_AND;
               default: alu_controls = ALUC_ADD;
            endcase
         end
         default: alu_controls = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I controller: Moore FSM sequencing a shared memory/ALU
// datapath, with memory wait states, full branch conditions and lui.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter int FULL_BRANCH = 1,
   parameter int MEM_WAIT    = 1,
   parameter int IMMSRC_W    = 3
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   multicycle_controller_if.slave bus
);

   state_t     state_r;
   state_t     state_n;
   moore_t     moore_r;
   logic       ready_s;
   logic       taken_s;
   logic       br_illegal_s;
   logic [2:0] imm_code_s;

   assign ready_s = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

   function automatic moore_t moore_decode(input state_t s);
      moore_t m;
      m = '0;
      case (s)
         S_FETCH: begin
            m.fetch     = 1'b1;
            m.alusrca   = SRCA_PC;
            m.alusrcb   = SRCB_FOUR;
            m.resultsrc = RES_ALU;
         end
         S_DECODE: begin
            m.alusrca = SRCA_OLDPC;
            m.alusrcb = SRCB_IMM;
         end
         S_MEMADR: begin
            m.alusrca = SRCA_RS1;
            m.alusrcb = SRCB_IMM;
         end
         S_MEMREAD: m.adrsrc = 1'b1;
         S_MEMWB: begin
            m.resultsrc = RES_DATA;
            m.regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            m.adrsrc   = 1'b1;
            m.memwrite = 1'b1;
         end
         S_EXECR: begin
            m.alusrca = SRCA_RS1;
            m.alusrcb = SRCB_RS2;
            m.alu_op  = ALUOP_FUNCT;
         end
         S_EXECI: begin
            m.alusrca = SRCA_RS1;
            m.alusrcb = SRCB_IMM;
            m.alu_op  = ALUOP_FUNCT;
         end
         S_LUI: begin
            m.alusrca = SRCA_ZERO;
            m.alusrcb = SRCB_IMM;
         end
         S_ALUWB: begin
            m.resultsrc = RES_ALUOUT;
            m.regwrite  = 1'b1;
         end
         S_JAL: begin
            m.alusrca = SRCA_OLDPC;
            m.alusrcb = SRCB_FOUR;
            m.pcwrite = 1'b1;
         end
         S_BRANCH: begin
            m.branch  = 1'b1;
            m.alusrca = SRCA_RS1;
            m.alusrcb = SRCB_RS2;
            m.alu_op  = ALUOP_SUB;
         end
         S_ILLEGAL: m.illegal = 1'b1;
         default:   m = '0;
      endcase
      return m;
   endfunction

   // next-state selection
   always_comb begin
      state_n = S_FETCH;
      case (state_r)
         S_FETCH: begin
            if (ready_s) begin
               state_n = S_DECODE;
            end else begin
               state_n = S_FETCH;
            end
         end
         S_DECODE: begin
            case (bus.op)
               OP_LOAD, OP_STORE: state_n = S_MEMADR;
               OP_RTYPE:          state_n = S_EXECR;
               OP_ITYPE:          state_n = S_EXECI;
               OP_BRANCH:         state_n = S_BRANCH;
               OP_JAL:            state_n = S_JAL;
               OP_LUI:            state_n = S_LUI;
               default:           state_n = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            if (bus.op[5]) begin
               state_n = S_MEMWRITE;
            end else begin
               state_n = S_MEMREAD;
            end
         end
         S_MEMREAD: begin
            if (ready_s) begin
               state_n = S_MEMWB;
            end else begin
               state_n = S_MEMREAD;
            end
         end
         S_MEMWRITE: begin
            if (ready_s) begin
               state_n = S_FETCH;
            end else begin
               state_n = S_MEMWRITE;
            end
         end
         S_EXECR, S_EXECI, S_LUI, S_JAL: state_n = S_ALUWB;
         default:                        state_n = S_FETCH;
      endcase
   end

   // state register with Moore outputs pre-decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_FETCH;
         moore_r <= moore_decode(S_FETCH);
      end else begin
         state_r <= state_n;
         moore_r <= moore_decode(state_n);
      end
   end

   // branch condition; funct3 010/011 are not valid branches
   always_comb begin
      taken_s      = 1'b0;
      br_illegal_s = 1'b0;
      if (FULL_BRANCH != 0) begin
         case (bus.funct3)
            3'b000:  taken_s = bus.zero;
            3'b001:  taken_s = !bus.zero;
            3'b100:  taken_s = bus.lt;
            3'b101:  taken_s = !bus.lt;
            3'b110:  taken_s = bus.ltu;
            3'b111:  taken_s = !bus.ltu;
            default: br_illegal_s = 1'b1;
         endcase
      end else begin
         taken_s = bus.zero ^ bus.funct3[0];
      end
   end

   // immediate format from opcode
   always_comb begin
      imm_code_s = IMM_I;
      case (bus.op)
         OP_STORE:  imm_code_s = IMM_S;
         OP_BRANCH: imm_code_s = IMM_B;
         OP_JAL:    imm_code_s = IMM_J;
         OP_LUI:    imm_code_s = IMM_U;
         default:   imm_code_s = IMM_I;
      endcase
   end

   mc_aludec u_aludec (
      .alu_op       (moore_r.alu_op),
      .funct3       (bus.funct3),
      .funct7_5     (bus.funct7_5),
      .op5          (bus.op[5]),
      .alu_controls (bus.alu_controls)
   );

   // strobes are gated by rst_n so none can fire while reset is held
   assign bus.pcwrite   = rst_n & ((moore_r.fetch & ready_s) | moore_r.pcwrite |
                                   (moore_r.branch & taken_s));
   assign bus.irwrite   = rst_n & moore_r.fetch & ready_s;
   assign bus.memwrite  = rst_n & moore_r.memwrite;
   assign bus.regwrite  = rst_n & moore_r.regwrite;
   assign bus.illegal   = rst_n & (moore_r.illegal | (moore_r.branch & br_illegal_s));
   assign bus.adrsrc    = moore_r.adrsrc;
   assign bus.resultsrc = moore_r.resultsrc;
   assign bus.alusrca   = moore_r.alusrca;
   assign bus.alusrcb   = moore_r.alusrcb;
   assign bus.immsrc    = IMMSRC_W'(imm_code_s);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: randomized instruction stream with planned wait states,
// expected per-cycle controls from a phase-level reference model.
module tb_multicycle_controller;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   multicycle_controller_if #(.IMMSRC_W(3)) bus ();
   multicycle_controller_if #(.IMMSRC_W(3)) bus_nb ();

   assign bus_nb.op        = bus.op;
   assign bus_nb.funct3    = bus.funct3;
   assign bus_nb.funct7_5  = bus.funct7_5;
   assign bus_nb.zero      = bus.zero;
   assign bus_nb.lt        = bus.lt;
   assign bus_nb.ltu       = bus.ltu;
   assign bus_nb.mem_ready = bus.mem_ready;

   multicycle_controller #(.FULL_BRANCH(1), .MEM_WAIT(1), .IMMSRC_W(3)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   multicycle_controller #(.FULL_BRANCH(0), .MEM_WAIT(1), .IMMSRC_W(3)) u_dut_nb (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_nb.slave)
   );

   typedef struct packed {
      logic       pcwrite;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [2:0] immsrc;
      logic [2:0] aluc;
      logic       illegal;
   } ctl_t;

   typedef struct packed {
      ctl_t c;
      logic pc_nb;
   } exp_t;

   typedef enum int {
      P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
      P_EXECR, P_EXECI, P_LUI, P_ALUWB, P_JAL, P_BRANCH, P_ILLEGAL
   } phase_t;

   exp_t   exp_q[$];
   phase_t seq_q[$];
   logic   rdy_q[$];
   int     checks = 0;
   int     errors = 0;
   bit     mon_en = 1'b0;

   function automatic logic [2:0] funct_alu(logic [6:0] op, logic [2:0] f3, logic f7);
      case (f3)
         3'b000:  return (f7 && op[5]) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // expected controls for one cycle of a given instruction phase
   function automatic ctl_t model(phase_t p, logic [6:0] op, logic [2:0] f3, logic f7,
                                  logic z, logic lt, logic ltu, logic rdy);
      ctl_t e;
      logic cond;
      e = '0;
      case (op)
         7'b0100011: e.immsrc = 3'b001;
         7'b1100011: e.immsrc = 3'b010;
         7'b1101111: e.immsrc = 3'b011;
         7'b0110111: e.immsrc = 3'b100;
         default:    e.immsrc = 3'b000;
      endcase
      cond = (f3[2:1] == 2'b00) ? z : (f3[2:1] == 2'b10) ? lt : ltu;
      case (p)
         P_FETCH: begin
            e.alusrcb = 2'b10; e.resultsrc = 2'b10; e.irwrite = rdy; e.pcwrite = rdy;
         end
         P_DECODE:   begin e.alusrca = 2'b01; e.alusrcb = 2'b01; end
         P_MEMADR:   begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
         P_MEMREAD:  e.adrsrc = 1'b1;
         P_MEMWB:    begin e.resultsrc = 2'b01; e.regwrite = 1'b1; end
         P_MEMWRITE: begin e.adrsrc = 1'b1; e.memwrite = 1'b1; end
         P_EXECR:    begin e.alusrca = 2'b10; e.aluc = funct_alu(op, f3, f7); end
         P_EXECI:    begin e.alusrca = 2'b10; e.alusrcb = 2'b01; e.aluc = funct_alu(op, f3, f7); end
         P_LUI:      begin e.alusrca = 2'b11; e.alusrcb = 2'b01; end
         P_ALUWB:    e.regwrite = 1'b1;
         P_JAL:      begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1'b1; end
         P_BRANCH: begin
            e.alusrca = 2'b10; e.aluc = 3'b001;
            if (f3[2:1] == 2'b01) e.illegal = 1'b1;
            else e.pcwrite = cond ^ f3[0];
         end
         P_ILLEGAL:  e.illegal = 1'b1;
         default:    e = '0;
      endcase
      return e;
   endfunction

   function automatic bit is_legal(logic [6:0] op);
      case (op)
         7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
         7'b1100011, 7'b1101111, 7'b0110111: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic ctl_t snap();
      return {bus.pcwrite, bus.adrsrc, bus.memwrite, bus.irwrite, bus.regwrite,
              bus.resultsrc, bus.alusrca, bus.alusrcb, bus.immsrc, bus.alu_controls,
              bus.illegal};
   endfunction

   function automatic void add_step(phase_t p, logic r);
      seq_q.push_back(p);
      rdy_q.push_back(r);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // plan one instruction's cycles, then drive them and queue expectations
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input logic lt, input logic ltu,
                            input int wf, input int wm, input int stop_after);
      ctl_t e;
      exp_t x;
      seq_q.delete();
      rdy_q.delete();
      for (int k = 0; k < wf; k++) add_step(P_FETCH, 1'b0);
      add_step(P_FETCH, 1'b1);
      add_step(P_DECODE, 1'($urandom));
      case (op)
         7'b0000011: begin
            add_step(P_MEMADR, 1'($urandom));
            for (int k = 0; k < wm; k++) add_step(P_MEMREAD, 1'b0);
            add_step(P_MEMREAD, 1'b1);
            add_step(P_MEMWB, 1'($urandom));
         end
         7'b0100011: begin
            add_step(P_MEMADR, 1'($urandom));
            for (int k = 0; k < wm; k++) add_step(P_MEMWRITE, 1'b0);
            add_step(P_MEMWRITE, 1'b1);
         end
         7'b0110011: begin add_step(P_EXECR, 1'($urandom)); add_step(P_ALUWB, 1'($urandom)); end
         7'b0010011: begin add_step(P_EXECI, 1'($urandom)); add_step(P_ALUWB, 1'($urandom)); end
         7'b0110111: begin add_step(P_LUI, 1'($urandom)); add_step(P_ALUWB, 1'($urandom)); end
         7'b1101111: begin add_step(P_JAL, 1'($urandom)); add_step(P_ALUWB, 1'($urandom)); end
         7'b1100011: add_step(P_BRANCH, 1'($urandom));
         default:    add_step(P_ILLEGAL, 1'($urandom));
      endcase
      for (int i = 0; i < seq_q.size(); i++) begin
         if (stop_after >= 0 && i >= stop_after) break;
         @(posedge clk);
         #1;
         bus.op        = op;
         bus.funct3    = f3;
         bus.funct7_5  = f7;
         bus.zero      = z;
         bus.lt        = lt;
         bus.ltu       = ltu;
         bus.mem_ready = rdy_q[i];
         e       = model(seq_q[i], op, f3, f7, z, lt, ltu, rdy_q[i]);
         x.c     = e;
         x.pc_nb = (seq_q[i] == P_BRANCH) ? (z ^ f3[0]) : e.pcwrite;
         exp_q.push_back(x);
         mon_en = 1'b1;
      end
   endtask

   // monitor: one expected record per cycle while enabled
   always @(negedge clk) begin
      exp_t x;
      ctl_t got;
      if (mon_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL underrun got=empty exp=record");
         end else begin
            x   = exp_q.pop_front();
            got = snap();
            if (got !== x.c) begin
               errors++;
               $display("FAIL ctl got=%h exp=%h", got, x.c);
            end
            checks++;
            if (bus_nb.pcwrite !== x.pc_nb) begin
               errors++;
               $display("FAIL pc_nb got=%b exp=%b", bus_nb.pcwrite, x.pc_nb);
            end
         end
      end
   end

   initial begin
      logic [6:0] rop;
      int         kind;
      rst_n         = 1'b0;
      bus.op        = 7'b0000000;
      bus.funct3    = 3'b000;
      bus.funct7_5  = 1'b0;
      bus.zero      = 1'b0;
      bus.lt        = 1'b0;
      bus.ltu       = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctl", 32'(snap()), 32'(model(P_FETCH, 7'b0000000, 3'b000, 1'b0,
                                               1'b0, 1'b0, 1'b0, 1'b0)));
      chk("reset_pc_nb", 32'(bus_nb.pcwrite), 32'd0);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3, -1);
      run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2, -1);
      run_instr(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, -1);
      run_instr(7'b1100011, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, -1);
      run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
      run_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, -1);
      run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, -1);

      for (int n = 0; n < 300; n++) begin
         kind = int'($urandom_range(0, 7));
         case (kind)
            0: rop = 7'b0000011;
            1: rop = 7'b0100011;
            2: rop = 7'b0110011;
            3: rop = 7'b0010011;
            4: rop = 7'b0110111;
            5: rop = 7'b1101111;
            6: rop = 7'b1100011;
            default: begin
               rop = 7'($urandom);
               if (is_legal(rop)) rop = 7'b1111111;
            end
         endcase
         run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
      end

      // reset asserted while a store is waiting on memory
      run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 4);
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("pre_reset_memwrite", 32'(bus.memwrite), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("reset_async_ctl", 32'(snap()), 32'(model(P_FETCH, 7'b0100011, 3'b010, 1'b0,
                                                     1'b0, 1'b0, 1'b0, 1'b0)));
      bus.mem_ready = 1'b1;
      #1;
      chk("reset_ready_ctl", 32'(snap()), 32'(model(P_FETCH, 7'b0100011, 3'b010, 1'b0,
                                                     1'b0, 1'b0, 1'b0, 1'b0)));
      chk("reset_ready_pc_nb", 32'(bus_nb.pcwrite), 32'd0);
      @(posedge clk);
      #1;
      chk("reset_held_ctl", 32'(snap()), 32'(model(P_FETCH, 7'b0100011, 3'b010, 1'b0,
                                                    1'b0, 1'b0, 1'b0, 1'b0)));
      bus.mem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_reset_idle", 32'(snap()), 32'(model(P_FETCH, 7'b0100011, 3'b010, 1'b0,
                                                     1'b0, 1'b0, 1'b0, 1'b0)));
      run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1, -1);
      run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1);
      run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, -1);

      @(negedge clk);
      #1;
      mon_en = 1'b0;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle controller for the RV32I core.
- A Moore FSM sequences each instruction over 3–5 cycles through a shared memory/ALU datapath.
- Adds memory wait-state handshaking, full branch-condition support (beq/bne/blt/bge/bltu/bgeu), U-type (lui) and an illegal-instruction pulse.
- Sits between the instruction register/flag outputs and the multicycle datapath mux/enable controls.

Parameters:
- FULL_BRANCH, 1: 1 = all six B-type conditions; 0 = beq/bne only (lt/ltu ignored, taken = zero ^ funct3[0]).
- MEM_WAIT, 1: 1 = honour mem_ready; 0 = mem_ready treated as constant 1.
- IMMSRC_W, 3: immsrc width; must be at least 3.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode from instruction register.
- funct3  in  3  instruction field.
- funct7_5  in  1  instruction bit 30.
- zero  in  1  ALU result == 0.
- lt  in  1  signed rs1 < rs2.
- ltu  in  1  unsigned rs1 < rs2.
- mem_ready  in  1  memory access completes this cycle.
- pcwrite  out  1  PC register enable.
- adrsrc  out  1  0 = PC, 1 = ALUOut as memory address.
- memwrite  out  1  data memory write strobe.
- irwrite  out  1  instruction register / OldPC enable.
- regwrite  out  1  register file write.
- resultsrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU result.
- alusrca  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- alusrcb  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- immsrc  out  IMMSRC_W  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- alu_controls  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- illegal  out  1  one-cycle pulse on undecodable opcode.

Behaviour:
- Reset: async on rst_n low; state = FETCH. While rst_n is low, pcwrite, irwrite, regwrite, memwrite and illegal are forced to 0. Other outputs take FETCH values.
- Outputs are Moore (state-decoded), except:
  - immsrc is combinational from op.
  - alu_controls is combinational from alu_op, funct3, funct7_5, op[5].
  - mem-gated strobes are qualified by mem_ready.
- alu_op encoding: 00 = add, 01 = sub, 10 = funct decode.
- Funct decode:
  - funct3 000: sub if funct7_5 & op[5], else add.
  - funct3 010: slt.
  - funct3 110: or.
  - funct3 111: and.
  - any other funct3: add.
- FETCH: adrsrc = 0, alusrca = 00, alusrcb = 10, alu_op = 00, resultsrc = 10. irwrite and pcwrite are asserted only in the cycle mem_ready = 1, which also moves to DECODE; otherwise stay in FETCH.
- DECODE: alusrca = 01, alusrcb = 01, alu_op = 00 (branch/jal target into ALUOut). Next state by op:
  - 0000011 / 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - any other op -> ILLEGAL
- MEMADR: alusrca = 10, alusrcb = 01, alu_op = 00; next is MEMREAD if op[5] = 0, else MEMWRITE.
- MEMREAD: adrsrc = 1; wait for mem_ready -> MEMWB.
- MEMWB: resultsrc = 01, regwrite = 1 -> FETCH.
- MEMWRITE: adrsrc = 1; memwrite held high until the cycle mem_ready = 1 (inclusive) -> FETCH.
- EXECR: alusrca = 10, alusrcb = 00, alu_op = 10 -> ALUWB.
- EXECI: as EXECR but alusrcb = 01 -> ALUWB.
- LUI: alusrca = 11, alusrcb = 01, alu_op = 00 -> ALUWB.
- ALUWB: resultsrc = 00, regwrite = 1 -> FETCH.
- JAL: alusrca = 01, alusrcb = 10, alu_op = 00, resultsrc = 00, pcwrite = 1 -> ALUWB (rd = OldPC + 4).
- BRANCH: alusrca = 10, alusrcb = 00, alu_op = 01, resultsrc = 00; pcwrite = taken -> FETCH.
  - funct3 000: taken = zero.
  - funct3 001: taken = !zero.
  - funct3 100: taken = lt.
  - funct3 101: taken = !lt.
  - funct3 110: taken = ltu.
  - funct3 111: taken = !ltu.
  - funct3 010/011: not taken and illegal pulse.
  - FULL_BRANCH = 0: taken = zero ^ funct3[0] for all funct3.
- ILLEGAL: illegal = 1 for exactly one cycle, no strobes -> FETCH.
- Unlisted strobes are 0 in every state; unused mux selects are 00.
- Latency: R/I/lui = 4 cycles, lw = 5, sw = 4, beq = 3, jal = 4, each plus wait cycles.
- rst_n asserted mid-instruction returns to FETCH immediately, with no strobe asserted in that cycle.
- Encoded states not enumerated -> FETCH.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state enum;
  - opcode localparams;
  - alu_op, alu_controls, resultsrc, alusrca, alusrcb and immsrc encodings.
- One sub-module, mc_aludec, holds the combinational ALU decode. The FSM, immsrc decode and branch-condition logic stay in the top.

Test Plan:
- add x3,x1,x2 (op 0110011, funct3 000, f7_5 0), mem_ready = 1 -> FETCH, DECODE, EXECR (alu_controls 000), ALUWB regwrite = 1; 4 cycles.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD -> irwrite exactly 1 cycle; MEMWB regwrite, resultsrc = 01; 10 cycles total.
- sw with mem_ready low 2 cycles in MEMWRITE -> memwrite high 3 consecutive cycles, adrsrc = 1, then FETCH.
- blt (funct3 100) with lt = 1 then lt = 0; FULL_BRANCH = 1 -> pcwrite 1 in BRANCH, then 0. With FULL_BRANCH = 0 and zero = 0 -> pcwrite = 0.
- op 1111111 -> ILLEGAL, illegal = 1 for 1 cycle, then FETCH; lui -> alusrca = 11, immsrc = 100, regwrite in ALUWB.
- rst_n low during MEMWRITE with mem_ready = 0 -> memwrite drops same cycle asynchronously; after release, FETCH with no strobes until mem_ready.
